// File: rtl/tone_pkg.sv
// Shared constants, types and the popcount helper for the tone oscillator bank.
package tone_pkg;

   localparam int NUM_CH = 12;
   localparam int DIV_W  = 18;
   localparam int MIX_W  = 4;

   typedef logic [DIV_W-1:0] div_t;

   typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

   function automatic logic [MIX_W-1:0] popcount(input logic [NUM_CH-1:0] v);
      logic [MIX_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         n = n + MIX_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/tone_channel.sv
// One note channel: half-period counter that toggles a square wave while the key is held.
module tone_channel
   import tone_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic key,
   input  div_t div,
   output logic wave
);

   ch_state_t state_d, state_q;
   div_t      cnt_d, cnt_q;
   logic      wave_d, wave_q;
   logic      go;

   assign go = key && (div != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wave_d  = wave_q;
      if (!go) begin
         state_d = CH_IDLE;
         cnt_d   = '0;
         wave_d  = 1'b0;
      end else if (state_q == CH_IDLE) begin
         state_d = CH_RUN;
         cnt_d   = '0;
         wave_d  = 1'b0;
      // >= rather than == so a shrinking divider restarts the half-period instead of wrapping
      end else if (cnt_q >= div - div_t'(1)) begin
         cnt_d  = '0;
         wave_d = ~wave_q;
      end else begin
         cnt_d = cnt_q + div_t'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CH_IDLE;
         cnt_q   <= '0;
         wave_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wave_q  <= wave_d;
      end
   end

   assign wave = wave_q;

endmodule

// File: rtl/tone_oscillator_bank.sv
// Twelve independent tone channels plus registered mixed level and active-key count.
module tone_oscillator_bank
   import tone_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*DIV_W-1:0] div,
   input  logic [NUM_CH-1:0]       key,
   output logic [NUM_CH-1:0]       wave,
   output logic [MIX_W-1:0]        mix,
   output logic [MIX_W-1:0]        active
);

   div_t              div_arr [NUM_CH];
   logic [NUM_CH-1:0] live;
   logic [MIX_W-1:0]  mix_d, mix_q;
   logic [MIX_W-1:0]  active_d, active_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign div_arr[k] = div[k*DIV_W +: DIV_W];
      assign live[k]    = key[k] && (div_arr[k] != '0);

      tone_channel u_ch (
         .clk  (clk),
         .rst  (rst),
         .key  (key[k]),
         .div  (div_arr[k]),
         .wave (wave[k])
      );
   end

   always_comb begin
      mix_d    = popcount(wave);
      active_d = popcount(live);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mix_q    <= '0;
         active_q <= '0;
      end else begin
         mix_q    <= mix_d;
         active_q <= active_d;
      end
   end

   assign mix    = mix_q;
   assign active = active_q;

endmodule

// File: doc/tone_oscillator_bank.md
# tone_oscillator_bank

Consumes the per-note divider values from `frequency_divider` (octave-shifted half-period counts, 18 bits each) and turns them into audible square waves. Each of 12 channels runs a half-period counter while its key is held. The bank emits a per-channel wave bit and a registered mixed level, the count of channels currently high, for the downstream PWM/DAC stage.

## Interface
- `NUM_CH`, 12: number of note channels, one per `frequency_divider` output.
- `DIV_W`, 18: divider value width, matching `div0..div11`.
- `MIX_W`, 4: width of mixed output; must hold `NUM_CH`.

- `clk`  in  1: single system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `div`  in  `NUM_CH*DIV_W`: packed divider values; channel k occupies bits `[k*DIV_W +: DIV_W]`, fed from `div0..div11`.
- `key`  in  `NUM_CH`: level key-held inputs (already debounced), bit k for channel k.
- `wave`  out  `NUM_CH`: per-channel square wave, registered.
- `mix`  out  `MIX_W`: registered population count of `wave`.
- `active`  out  `MIX_W`: registered count of channels with `key[k]=1` and `div_k!=0`.

## Operation
- Per channel: state IDLE / RUN, an 18-bit `cnt`, and the `wave` register.
- IDLE, entered on reset or whenever the channel is not running:
  - `cnt=0`, `wave=0`.
  - Moves to RUN on the edge where `key[k]=1` and `div_k!=0`.
- RUN, on each edge:
  - If `cnt >= div_k-1`: `cnt<=0` and `wave<=~wave`.
  - Otherwise: `cnt<=cnt+1`.
  - Wave period is `2*div_k` clocks.
  - Uses `>=`, not `==`. If `div_k` drops below the current `cnt`, the channel toggles on the next edge and restarts. No wrap through 2^18.
- RUN leaves to IDLE on the edge where `key[k]=0` or `div_k==0`. `cnt` and `wave` clear on that same edge. Release never leaves a stuck-high wave.
- Divider changes during RUN (octave shift) take effect immediately. The phase is not reset unless the `>=` rule fires.
- `div_k==1` toggles every clock, giving a period of 2.
- Channels are fully independent; simultaneous key changes on multiple channels need no arbitration.
- `mix` is the popcount of the current `wave` register, registered.
- `active` is the popcount of `key & (div!=0)`, registered.
- Arithmetic: compare is `cnt >= div_k - 1` with `div_k != 0` guaranteed by the FSM, so there is no underflow. `mix` ≤ `NUM_CH`, so it never overflows `MIX_W`.

## Timing
- Reset: all `wave=0`, `mix=0`, `active=0`, all `cnt=0`, all channels IDLE. Asserting `rst` mid-operation clears everything asynchronously, regardless of key state.
- Key press sampled at edge E0 (IDLE→RUN, `cnt=0`):
  - First `wave` rise at edge E0+`div_k`.
  - First fall at E0+`2*div_k`.
- Key release sampled at edge E: `wave=0` after E.
- `mix` lags `wave` by exactly 1 clock.
- `active` lags `key` by 1 clock.
- No handshake. Inputs are sampled every edge; `div` is assumed stable relative to `clk`, since it comes from the same clock domain.

## Structure
- Package `tone_pkg`:
  - `NUM_CH=12`, `DIV_W=18`, `MIX_W=4`.
  - `typedef logic [DIV_W-1:0] div_t`.
  - `typedef enum logic {CH_IDLE, CH_RUN} ch_state_t`.
- Sub-module `tone_channel` (clk, rst, key, div, wave): one FSM+counter. Generated `NUM_CH` times in the bank.
- The top level holds the div unpacking, the two popcounts and their output registers.

## Test plan
- Reset: `rst=1` with keys held and `div=4` → `wave=0`, `mix=0`, `active=0`. After release of `rst`, key0 held → `wave[0]` rises 4 clocks after the press edge, falls 8 clocks after it, then repeats with period 8.
- Simultaneous: keys 0, 4, 7 pressed on the same edge with `div=3,5,7` → `active=3` one clock later. Periods are 6/10/14. `mix` equals the popcount of `wave` delayed one clock. At the edge where all three are high, `mix=3` on the next clock.
- Release mid-high: key0 released while `wave[0]=1` → `wave[0]=0` after that edge. `mix` decrements on the following edge. Re-press restarts from `cnt=0`.
- Divider shrink: `div0=100`; after 60 clocks in RUN set `div0=50` → toggle on the next edge, then period 100.
- Boundaries: `div0=1` → toggles every clock. `div0=0` with key held → `wave[0]=0`, `active=0`. All 12 keys with `div=1` → `mix` alternates 12/0.
- Async reset mid-run: pulse `rst` between edges with several waves high → outputs clear immediately without a clock edge.
